// File: rtl/pcfx_mem_loader.sv
// PC-FX memory loader: buffers HPS download writes in a small FIFO and arbitrates
// them against CPU accesses onto a single shared-memory request/ack port.
module pcfx_mem_loader #(
  parameter logic [20:0] BIOS_BASE  = 21'h000000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [20:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic [1:0]  cpu_be,
  output logic        cpu_ack,
  output logic [15:0] cpu_dout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [20:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        load_done,
  output logic        overflow
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, CPU} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ioctl_wait_q, ioctl_wait_d;
  logic          overflow_q, overflow_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [20:0]   mem_addr_q, mem_addr_d;
  logic [15:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]    mem_be_q, mem_be_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [15:0]   cpu_dout_q, cpu_dout_d;
  logic          load_done_q, load_done_d;
  logic          dl_prev_q, dl_prev_d;
  logic          wrote_q, wrote_d;
  logic          armed_q, armed_d;

  logic [20:0]   fifo_addr_mem [FIFO_DEPTH];
  logic [15:0]   fifo_data_mem [FIFO_DEPTH];

  logic          accept, push, pop, full, dl_fell;
  logic [20:0]   push_addr;
  logic          unused_bits;

  assign unused_bits = ^{ioctl_addr[0], ioctl_index[7:6]};

  // Download-side FIFO bookkeeping and the stall/overflow flags
  always_comb begin
    accept       = ioctl_wr && ioctl_download && (ioctl_index[5:0] <= 6'h01) &&
                   (ioctl_addr[24:21] == 4'h0);
    push_addr    = BIOS_BASE + ioctl_addr[21:1];
    full         = (count_q == DEPTH_C);
    pop          = (state_q == LOAD) && mem_ack;
    push         = accept && (!full || pop);
    wr_ptr_d     = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d      = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
    ioctl_wait_d = (count_d >= DEPTH_C - CNT_ONE);
    overflow_d   = overflow_q || (accept && full && !pop);
  end

  // A download is "armed" once it has fallen after at least one accepted write
  always_comb begin
    dl_prev_d   = ioctl_download;
    dl_fell     = dl_prev_q && !ioctl_download;
    wrote_d     = dl_fell ? 1'b0 : (wrote_q || accept);
    load_done_d = armed_q && (count_q == '0) && (state_q == IDLE);
    armed_d     = (armed_q && !load_done_d) || (dl_fell && wrote_q);
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_q] <= push_addr;
      fifo_data_mem[wr_ptr_q] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ioctl_wait_q <= 1'b0;
      overflow_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_dout_q   <= '0;
      load_done_q  <= 1'b0;
      dl_prev_q    <= 1'b0;
      wrote_q      <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ioctl_wait_q <= ioctl_wait_d;
      overflow_q   <= overflow_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_dout_q   <= cpu_dout_d;
      load_done_q  <= load_done_d;
      dl_prev_q    <= dl_prev_d;
      wrote_q      <= wrote_d;
      armed_q      <= armed_d;
    end
  end

  // The cycle carrying cpu_ack must not relaunch the request the CPU is about to drop
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0)               state_d = LOAD;
        else if (cpu_req && !cpu_ack_q)  state_d = CPU;
      end
      LOAD:    if (mem_ack) state_d = IDLE;
      CPU:     if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    cpu_ack_d   = 1'b0;
    cpu_dout_d  = cpu_dout_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_be_d    = 2'b11;
          mem_addr_d  = fifo_addr_mem[rd_ptr_q];
          mem_wdata_d = fifo_data_mem[rd_ptr_q];
        end else if (cpu_req && !cpu_ack_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_we;
          mem_be_d    = cpu_be;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_din;
        end
      end
      LOAD: if (mem_ack) mem_req_d = 1'b0;
      CPU: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          cpu_ack_d = 1'b1;
          if (!mem_we_q) cpu_dout_d = mem_rdata;
        end
      end
      default: mem_req_d = 1'b0;
    endcase
  end

  assign ioctl_wait = ioctl_wait_q;
  assign overflow   = overflow_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_dout   = cpu_dout_q;
  assign load_done  = load_done_q;

endmodule
